// File: rtl/uart_byte_packer_if.sv
// uart_byte_packer_if: byte-in / packed-word-out bus of the UART byte packer.
// The master modport is the packer's own view (it accepts beats and drives
// the packed word); the slave modport is the view of its surroundings (the
// UART receiver feeding beats and the downstream consumer taking words).
interface uart_byte_packer_if #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 224
);
  logic             s_valid;
  logic [W_IN-1:0]  s_data;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic [W_OUT-1:0] m_data;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/uart_byte_packer.sv
// uart_byte_packer: collects W_IN-bit UART beats little-endian into one
// W_OUT-bit word and offers it on an AXI-Stream style valid/ready port.
// The output word sits in its own register, so the next word keeps filling
// while the previous one waits for m_ready. A beat that arrives while the
// packer is stalled on its final beat is dropped and flagged on overrun.
// Optional feature macro: UART_BYTE_PACKER_TIMEOUT_EN -- discards a partial
// word after TIMEOUT_CYCLES idle clocks and pulses timeout.
module uart_byte_packer #(
  parameter int W_IN           = 8,
  parameter int W_OUT          = 224,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               rst,
  uart_byte_packer_if.master bus,
  output logic               overrun,
  output logic               timeout
);

  localparam int NUM_BEATS = (W_OUT + W_IN - 1) / W_IN;
  localparam int ACC_W     = NUM_BEATS * W_IN;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] merged;
  logic [W_OUT-1:0] out_word;
  logic             out_valid;
  logic             overrun_q;
  logic             last_beat;
  logic             s_ready_int;
  logic             accept;

  // Only the final beat can stall: it needs the output register to be free
  // (or being emptied this very cycle).
  assign last_beat   = (cnt == LAST_BEAT);
  assign s_ready_int = !(last_beat && out_valid && !bus.m_ready);
  assign accept      = bus.s_valid && s_ready_int;

  assign bus.s_ready = s_ready_int;
  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_word;
  assign overrun     = overrun_q;

  // Drop the incoming beat into its little-endian slot of the word in progress
  always_comb begin
    merged = acc;
    merged[int'(cnt) * W_IN +: W_IN] = bus.s_data;
  end

`ifdef UART_BYTE_PACKER_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        idle_expired;
  logic        timeout_q;

  assign idle_expired = (cnt != '0) && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign timeout      = timeout_q;

  // Count idle clocks while a partial word is pending and flag its discard
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= !accept && idle_expired;
      if (accept || (cnt == '0) || idle_expired) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Beat counter and accumulator; both restart once a word is handed over
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      if (last_beat) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= merged;
      end
    end
`ifdef UART_BYTE_PACKER_TIMEOUT_EN
    else if (idle_expired) begin
      cnt <= '0;
      acc <= '0;
    end
`endif
  end

  // Output word register: reload on completion, otherwise hold until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      out_word  <= '0;
      out_valid <= 1'b0;
    end else if (accept && last_beat) begin
      out_word  <= merged[W_OUT-1:0];
      out_valid <= 1'b1;
    end else if (out_valid && bus.m_ready) begin
      out_valid <= 1'b0;
    end
  end

  // One-cycle flag for a beat that arrived while the packer was stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= bus.s_valid && !s_ready_int;
    end
  end

endmodule

// File: tb/tb_uart_byte_packer.sv
// tb_uart_byte_packer: drives directed and random UART beats into the packer
// and compares every cycle against a queue-based model of the byte stream.
// Honours UART_BYTE_PACKER_TIMEOUT_EN the same way the design does.
module tb_uart_byte_packer;

  localparam int W_IN  = 8;
  localparam int W_OUT = 20;
  localparam int TO    = 50;
  localparam int NB    = (W_OUT + W_IN - 1) / W_IN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overrun;
  logic timeout;

  int vectors     = 0;
  int miscompares = 0;

  uart_byte_packer_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

  uart_byte_packer #(
    .W_IN(W_IN),
    .W_OUT(W_OUT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master),
    .overrun(overrun),
    .timeout(timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference model: the beats of the word being collected, and the word on offer
  logic [W_IN-1:0]  beats[$];
  logic             exp_valid  = 1'b0;
  logic [W_OUT-1:0] exp_data   = '0;
  logic             exp_over   = 1'b0;
  logic             exp_to     = 1'b0;
  int               quiet      = 0;
  bit               model_live = 1'b0;

  function automatic logic [W_OUT-1:0] assemble();
    logic [31:0] word;
    word = '0;
    for (int k = 0; k < beats.size(); k++) begin
      word = word | (32'(beats[k]) << (W_IN * k));
    end
    return word[W_OUT-1:0];
  endfunction

  function automatic logic model_ready();
    return !((beats.size() == NB - 1) && exp_valid && !bus.m_ready);
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Advance the model on every rising edge from the inputs the bench drove
  always @(posedge clk) begin : model_step
    logic rdy;
    if (rst) begin
      beats.delete();
      exp_valid  = 1'b0;
      exp_data   = '0;
      exp_over   = 1'b0;
      exp_to     = 1'b0;
      quiet      = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      rdy      = model_ready();
      exp_over = bus.s_valid && !rdy;
      exp_to   = 1'b0;
      if (exp_valid && bus.m_ready) exp_valid = 1'b0;
      if (bus.s_valid && rdy) begin
        beats.push_back(bus.s_data);
        quiet = 0;
        if (beats.size() == NB) begin
          exp_data  = assemble();
          exp_valid = 1'b1;
          beats.delete();
        end
      end else if (beats.size() != 0) begin
`ifdef UART_BYTE_PACKER_TIMEOUT_EN
        quiet++;
        if (quiet == TO) begin
          beats.delete();
          quiet  = 0;
          exp_to = 1'b1;
        end
`endif
      end
    end
  end

  // Compare the DUT against the model mid-cycle, after inputs have settled
  always begin
    @(negedge clk);
    #2;
    if (model_live) begin
      check_output("s_ready", 32'(bus.s_ready), 32'(model_ready()));
      check_output("m_valid", 32'(bus.m_valid), 32'(exp_valid));
      check_output("m_data",  32'(bus.m_data),  32'(exp_data));
      check_output("overrun", 32'(overrun),     32'(exp_over));
      check_output("timeout", 32'(timeout),     32'(exp_to));
    end
  end

  task automatic apply_stimulus(input logic v, input logic [W_IN-1:0] d, input logic r);
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    do_reset();
    check_output("reset_m_valid", 32'(bus.m_valid), 32'd0);
    check_output("reset_m_data",  32'(bus.m_data),  32'd0);
    check_output("reset_s_ready", 32'(bus.s_ready), 32'd1);
    check_output("reset_overrun", 32'(overrun),     32'd0);

    // Basic word, taken at once
    apply_stimulus(1'b1, 8'h21, 1'b1);
    apply_stimulus(1'b1, 8'h43, 1'b1);
    apply_stimulus(1'b1, 8'hF5, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("basic_valid", 32'(bus.m_valid), 32'd1);
    check_output("basic_data",  32'(bus.m_data),  32'h54321);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("basic_drop",  32'(bus.m_valid), 32'd0);

    // Backpressure: second word fills behind a held first word
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b1, 8'h02, 1'b0);
    apply_stimulus(1'b1, 8'h03, 1'b0);
    apply_stimulus(1'b1, 8'h04, 1'b0);
    check_output("held_data", 32'(bus.m_data), 32'h30201);
    apply_stimulus(1'b1, 8'h05, 1'b0);
    check_output("mid_ready", 32'(bus.s_ready), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("stall_ready", 32'(bus.s_ready), 32'd0);
    check_output("stall_data",  32'(bus.m_data),  32'h30201);
    apply_stimulus(1'b1, 8'h06, 1'b1);
    check_output("release_ready", 32'(bus.s_ready), 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("nobubble_valid", 32'(bus.m_valid), 32'd1);
    check_output("nobubble_data",  32'(bus.m_data),  32'h60504);
    apply_stimulus(1'b1, 8'h07, 1'b0);
    apply_stimulus(1'b1, 8'h08, 1'b0);
    apply_stimulus(1'b1, 8'h09, 1'b0);
    check_output("overrun_ready", 32'(bus.s_ready), 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("overrun_pulse", 32'(overrun),    32'd1);
    check_output("overrun_data",  32'(bus.m_data), 32'h60504);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    check_output("overrun_clear", 32'(overrun),    32'd0);
    apply_stimulus(1'b1, 8'h0A, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("third_valid", 32'(bus.m_valid), 32'd1);
    check_output("third_data",  32'(bus.m_data),  32'hA0807);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    // Reset with a pending word and a partial word in flight
    apply_stimulus(1'b1, 8'h01, 1'b0);
    apply_stimulus(1'b1, 8'h02, 1'b0);
    apply_stimulus(1'b1, 8'h03, 1'b0);
    apply_stimulus(1'b1, 8'h04, 1'b0);
    apply_stimulus(1'b1, 8'h05, 1'b0);
    do_reset();
    check_output("rst_valid", 32'(bus.m_valid), 32'd0);
    check_output("rst_data",  32'(bus.m_data),  32'd0);
    apply_stimulus(1'b1, 8'hAA, 1'b1);
    apply_stimulus(1'b1, 8'hBB, 1'b1);
    apply_stimulus(1'b1, 8'h0C, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    check_output("post_rst_valid", 32'(bus.m_valid), 32'd1);
    check_output("post_rst_data",  32'(bus.m_data),  32'hCBBAA);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    // Idle partial word: discarded only when the timeout feature is built in
    apply_stimulus(1'b1, 8'h00, 1'b1);
    pulses = 0;
    for (int i = 0; i < TO + 1; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1);
      if (timeout === 1'b1) pulses++;
    end
`ifdef UART_BYTE_PACKER_TIMEOUT_EN
    check_output("timeout_pulses", 32'(pulses), 32'd1);
`else
    check_output("timeout_pulses", 32'(pulses), 32'd0);
`endif
    apply_stimulus(1'b1, 8'h11, 1'b1);
    apply_stimulus(1'b1, 8'h22, 1'b1);
    apply_stimulus(1'b1, 8'h03, 1'b1);
`ifndef UART_BYTE_PACKER_TIMEOUT_EN
    check_output("no_to_valid", 32'(bus.m_valid), 32'd1);
    check_output("no_to_data",  32'(bus.m_data),  32'h21100);
`endif
    apply_stimulus(1'b0, 8'h00, 1'b1);
`ifdef UART_BYTE_PACKER_TIMEOUT_EN
    check_output("to_valid", 32'(bus.m_valid), 32'd1);
    check_output("to_data",  32'(bus.m_data),  32'h32211);
`endif

    // Random traffic with occasional long gaps and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 199) == 0) begin
        for (int g = 0; g < TO + 10; g++) begin
          apply_stimulus(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
      end else begin
        apply_stimulus(1'($urandom_range(0, 9) < 4), 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
